// File: rtl/ifill_arb.sv
// rtl/ifill_arb.sv - arbitrates icache line fills and data accesses onto one nibble-wide memory port
// Fills are buffered whole, then replayed to the icache as one gap-free strobe burst.
module ifill_arb #(
  parameter int PA          = 22,
  parameter int RV          = 16,
  parameter int LINE_LENGTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_req,
  input  logic                              i_pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0] i_tag,
  output logic                              fill_busy,
  output logic                              wstrobe_d,
  output logic [3:0]                        dread,
  input  logic                              d_req,
  input  logic                              d_write,
  input  logic [PA-1:0]                     d_addr,
  input  logic [RV-1:0]                     d_wdata,
  output logic                              d_ack,
  output logic [RV-1:0]                     d_rdata,
  output logic                              mem_req,
  input  logic                              mem_gnt,
  output logic                              mem_write,
  output logic [PA-1:0]                     mem_addr,
  output logic                              mem_len,
  input  logic                              mem_strobe,
  input  logic [3:0]                        mem_rnib,
  output logic [3:0]                        mem_wnib
);

  localparam int OFFW = $clog2(LINE_LENGTH);
  localparam int CW   = $clog2(LINE_LENGTH * 2);
  localparam logic [CW-1:0] FILL_LAST = CW'(LINE_LENGTH * 2 - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(RV / 4 - 1);

  typedef enum logic [2:0] {IDLE, IREQ, IXFER, REPLAY, DREQ, DXFER, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     last_i_q, last_i_d;
  logic                     served_q, served_d;
  logic [PA-1:0]            addr_q, addr_d;
  logic                     write_q, write_d;
  logic [LINE_LENGTH*8-1:0] line_q, line_d;
  logic [RV-1:0]            rdata_q, rdata_d;
  logic                     fill_rq;
  logic                     pick_fill;

  assign fill_rq = i_req && i_pull;
  // Until anything has completed there is no "last served" side, so data takes the first tie.
  assign pick_fill = fill_rq && (!d_req || (served_q && !last_i_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_i_q <= 1'b0;
      served_q <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      line_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_i_q <= last_i_d;
      served_q <= served_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      line_q   <= line_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_i_d = last_i_q;
    served_d = served_q;
    addr_d   = addr_q;
    write_d  = write_q;
    line_d   = line_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (fill_rq || d_req) begin
          cnt_d = '0;
          if (pick_fill) begin
            state_d = IREQ;
            addr_d  = {i_tag, {OFFW{1'b0}}};
            write_d = 1'b0;
          end else begin
            state_d = DREQ;
            addr_d  = d_addr & ~PA'(1);
            write_d = d_write;
          end
        end
      end
      IREQ: begin
        if (mem_gnt) begin
          state_d = IXFER;
          cnt_d   = '0;
        end
      end
      IXFER: begin
        if (mem_strobe) begin
          line_d[4*cnt_q +: 4] = mem_rnib;
          if (cnt_q == FILL_LAST) begin
            state_d = REPLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPLAY: begin
        if (cnt_q == FILL_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          last_i_d = 1'b1;
          served_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DREQ: begin
        if (mem_gnt) begin
          state_d = DXFER;
          cnt_d   = '0;
        end
      end
      DXFER: begin
        if (mem_strobe) begin
          // Memory delivers the odd nibble of each byte first.
          if (!write_q) rdata_d[4*(cnt_q ^ CW'(1)) +: 4] = mem_rnib;
          if (cnt_q == DATA_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        last_i_d = 1'b0;
        served_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == IREQ) || (state_q == DREQ);
    mem_len   = (state_q == IREQ) || (state_q == IXFER) || (state_q == REPLAY);
    mem_write = write_q;
    mem_addr  = addr_q;
    fill_busy = (state_q == IREQ) || (state_q == IXFER) || (state_q == REPLAY);
    wstrobe_d = (state_q == REPLAY);
    d_ack     = (state_q == DONE);
    d_rdata   = rdata_q;
    dread     = 4'h0;
    mem_wnib  = 4'h0;
    if (state_q == REPLAY) dread = line_q[4*cnt_q +: 4];
    if (state_q == DXFER && write_q) mem_wnib = d_wdata[4*(cnt_q ^ CW'(1)) +: 4];
  end

endmodule

// File: tb/tb_ifill_arb.sv
// tb/tb_ifill_arb.sv - directed self-checking bench for ifill_arb
module tb_ifill_arb;
  localparam int PA = 22;
  localparam int RV = 16;
  localparam int LL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, i_pull = 1'b0;
  logic [19:0]   i_tag = '0;
  logic          fill_busy, wstrobe_d;
  logic [3:0]    dread;
  logic          d_req = 1'b0, d_write = 1'b0;
  logic [PA-1:0] d_addr = '0;
  logic [RV-1:0] d_wdata = '0;
  logic          d_ack;
  logic [RV-1:0] d_rdata;
  logic          mem_req, mem_write, mem_len;
  logic          mem_gnt = 1'b0, mem_strobe = 1'b0;
  logic [PA-1:0] mem_addr;
  logic [3:0]    mem_rnib = '0, mem_wnib;

  int checks = 0;
  int errors = 0;
  int wstrobe_cnt = 0;
  int ack_cnt = 0;

  ifill_arb #(.PA(PA), .RV(RV), .LINE_LENGTH(LL)) dut (
    .clk(clk), .reset(rst_n),
    .i_req(i_req), .i_pull(i_pull), .i_tag(i_tag),
    .fill_busy(fill_busy), .wstrobe_d(wstrobe_d), .dread(dread),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_strobe(mem_strobe),
    .mem_rnib(mem_rnib), .mem_wnib(mem_wnib)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wstrobe_d === 1'b1) wstrobe_cnt <= wstrobe_cnt + 1;
    if (d_ack === 1'b1) ack_cnt <= ack_cnt + 1;
  end

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse_gnt;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
  endtask

  task automatic serve_data(input logic [15:0] nibs, output bit ok);
    pulse_gnt();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) @(negedge clk);
      mem_strobe = 1'b1;
      mem_rnib = nibs[4*k +: 4];
      @(negedge clk);
      mem_strobe = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (d_ack === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic serve_fill(input logic [31:0] nibs, output bit ok);
    pulse_gnt();
    for (int k = 0; k < 8; k++) begin
      if (k % 3 == 1) @(negedge clk);
      mem_strobe = 1'b1;
      mem_rnib = nibs[4*k +: 4];
      @(negedge clk);
      mem_strobe = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (fill_busy === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, wstrobe_d, fill_busy, d_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {mem_req, wstrobe_d, fill_busy, d_ack});
    end
    checks++;
    if (dread !== 4'h0 || mem_wnib !== 4'h0 || d_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_data got dread=%h wnib=%h rdata=%h exp 0", dread, mem_wnib, d_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle got mem_req=%b exp 0", mem_req);
    end
  endtask

  task automatic test_fill;
    bit ok;
    int ws0;
    ws0 = wstrobe_cnt;
    i_tag = 20'h12345; i_req = 1'b1; i_pull = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fill_req got timeout exp mem_req"); end
    checks++;
    if (mem_addr !== 22'h48D14 || mem_len !== 1'b1 || mem_write !== 1'b0) begin
      errors++; $display("FAIL fill_cmd got addr=%h len=%b wr=%b exp 48d14 1 0", mem_addr, mem_len, mem_write);
    end
    checks++;
    if (fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_early got %b exp 1", fill_busy); end
    i_req = 1'b0; i_pull = 1'b0;
    pulse_gnt();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_drop got %b exp 0", mem_req); end
    for (int n = 1; n <= 8; n++) begin
      if (n % 3 == 0) @(negedge clk);
      mem_strobe = 1'b1;
      mem_rnib = 4'(n);
      @(negedge clk);
      mem_strobe = 1'b0;
    end
    checks++;
    if (wstrobe_cnt != ws0) begin errors++; $display("FAIL fill_early_wstrobe got %0d exp 0", wstrobe_cnt - ws0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wstrobe_d !== 1'b1 || dread !== 4'(i + 1) || fill_busy !== 1'b1) begin
        errors++; $display("FAIL fill_replay%0d got ws=%b dread=%h busy=%b exp 1 %h 1", i, wstrobe_d, dread, fill_busy, 4'(i + 1));
      end
      @(negedge clk);
    end
    checks++;
    if (wstrobe_d !== 1'b0 || fill_busy !== 1'b0) begin
      errors++; $display("FAIL fill_end got ws=%b busy=%b exp 0 0", wstrobe_d, fill_busy);
    end
    checks++;
    if (wstrobe_cnt - ws0 != 8) begin errors++; $display("FAIL fill_wstrobe_count got %0d exp 8", wstrobe_cnt - ws0); end
  endtask

  task automatic test_load;
    bit ok;
    int a0, ws0;
    a0 = ack_cnt; ws0 = wstrobe_cnt;
    d_req = 1'b1; d_write = 1'b0; d_addr = 22'h001235;
    wait_req(ok);
    checks++;
    if (!ok || mem_addr !== 22'h001234 || mem_len !== 1'b0 || mem_write !== 1'b0 || fill_busy !== 1'b0) begin
      errors++; $display("FAIL load_cmd got ok=%b addr=%h len=%b wr=%b busy=%b exp 1 001234 0 0 0", ok, mem_addr, mem_len, mem_write, fill_busy);
    end
    serve_data(16'hDCBA, ok);
    checks++;
    if (!ok || d_rdata !== 16'hCDAB) begin
      errors++; $display("FAIL load_data got ack=%b rdata=%h exp 1 cdab", ok, d_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
    checks++;
    if (d_ack !== 1'b0 || d_rdata !== 16'hCDAB) begin
      errors++; $display("FAIL load_hold got ack=%b rdata=%h exp 0 cdab", d_ack, d_rdata);
    end
    checks++;
    if (ack_cnt - a0 != 1 || wstrobe_cnt != ws0) begin
      errors++; $display("FAIL load_pulses got acks=%0d ws=%0d exp 1 0", ack_cnt - a0, wstrobe_cnt - ws0);
    end
  endtask

  task automatic test_store;
    bit ok;
    int a0, ws0;
    logic [15:0] exp_seq;
    exp_seq = 16'h6587;
    a0 = ack_cnt; ws0 = wstrobe_cnt;
    d_req = 1'b1; d_write = 1'b1; d_addr = 22'h000100; d_wdata = 16'h5678;
    wait_req(ok);
    checks++;
    if (!ok || mem_write !== 1'b1 || mem_len !== 1'b0 || mem_addr !== 22'h000100) begin
      errors++; $display("FAIL store_cmd got ok=%b wr=%b len=%b addr=%h exp 1 1 0 000100", ok, mem_write, mem_len, mem_addr);
    end
    pulse_gnt();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) @(negedge clk);
      checks++;
      if (mem_wnib !== exp_seq[4*k +: 4]) begin
        errors++; $display("FAIL store_wnib%0d got %h exp %h", k, mem_wnib, exp_seq[4*k +: 4]);
      end
      mem_strobe = 1'b1;
      mem_rnib = 4'hF;
      @(negedge clk);
      mem_strobe = 1'b0;
    end
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 16'hCDAB) begin
      errors++; $display("FAIL store_done got ack=%b rdata=%h exp 1 cdab", d_ack, d_rdata);
    end
    d_req = 1'b0; d_write = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_cnt - a0 != 1 || wstrobe_cnt != ws0) begin
      errors++; $display("FAIL store_pulses got acks=%0d ws=%0d exp 1 0", ack_cnt - a0, wstrobe_cnt - ws0);
    end
  endtask

  task automatic test_arbitration;
    bit ok;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_tag = 20'h00001; i_req = 1'b1; i_pull = 1'b1;
    d_req = 1'b1; d_write = 1'b0; d_addr = 22'h000010;
    wait_req(ok);
    checks++;
    if (!ok || mem_len !== 1'b0) begin errors++; $display("FAIL tie1_data got ok=%b len=%b exp 1 0", ok, mem_len); end
    serve_data(16'h4321, ok);
    d_req = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || mem_len !== 1'b1 || mem_addr !== 22'h000004) begin
      errors++; $display("FAIL tie1_fill got ok=%b len=%b addr=%h exp 1 1 000004", ok, mem_len, mem_addr);
    end
    i_req = 1'b0; i_pull = 1'b0;
    serve_fill(32'h0, ok);
    i_req = 1'b1; i_pull = 1'b1; d_req = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || mem_len !== 1'b0) begin errors++; $display("FAIL tie2_data got ok=%b len=%b exp 1 0", ok, mem_len); end
    serve_data(16'h1111, ok);
    wait_req(ok);
    checks++;
    if (!ok || mem_len !== 1'b1) begin errors++; $display("FAIL tie3_fill got ok=%b len=%b exp 1 1", ok, mem_len); end
    i_req = 1'b0; i_pull = 1'b0;
    serve_fill(32'h0, ok);
    wait_req(ok);
    checks++;
    if (!ok || mem_len !== 1'b0) begin errors++; $display("FAIL pending_data got ok=%b len=%b exp 1 0", ok, mem_len); end
    serve_data(16'h9876, ok);
    d_req = 1'b0;
    checks++;
    if (!ok || d_rdata !== 16'h8967) begin errors++; $display("FAIL pending_rdata got ok=%b rdata=%h exp 1 8967", ok, d_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_fill;
    bit ok;
    int a0, ws0;
    a0 = ack_cnt; ws0 = wstrobe_cnt;
    i_tag = 20'h00AAA; i_req = 1'b1; i_pull = 1'b1;
    wait_req(ok);
    i_req = 1'b0; i_pull = 1'b0;
    pulse_gnt();
    for (int k = 0; k < 3; k++) begin
      mem_strobe = 1'b1;
      mem_rnib = 4'hE;
      @(negedge clk);
      mem_strobe = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, wstrobe_d, fill_busy, d_ack, mem_len} !== 5'b00000) begin
      errors++; $display("FAIL abort_ctrl got %b exp 00000", {mem_req, wstrobe_d, fill_busy, d_ack, mem_len});
    end
    checks++;
    if (dread !== 4'h0 || mem_wnib !== 4'h0 || d_rdata !== 16'h0) begin
      errors++; $display("FAIL abort_data got dread=%h wnib=%h rdata=%h exp 0", dread, mem_wnib, d_rdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wstrobe_cnt != ws0 || ack_cnt != a0) begin
      errors++; $display("FAIL abort_pulses got ws=%0d acks=%0d exp 0 0", wstrobe_cnt - ws0, ack_cnt - a0);
    end
    i_tag = 20'h00BBB; i_req = 1'b1; i_pull = 1'b1;
    wait_req(ok);
    checks++;
    if (!ok || mem_addr !== 22'h002EEC) begin errors++; $display("FAIL refill_cmd got ok=%b addr=%h exp 1 002eec", ok, mem_addr); end
    i_req = 1'b0; i_pull = 1'b0;
    pulse_gnt();
    for (int n = 0; n < 8; n++) begin
      mem_strobe = 1'b1;
      mem_rnib = 4'(n + 9);
      @(negedge clk);
      mem_strobe = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wstrobe_d !== 1'b1 || dread !== 4'(i + 9)) begin
        errors++; $display("FAIL refill_replay%0d got ws=%b dread=%h exp 1 %h", i, wstrobe_d, dread, 4'(i + 9));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_load();
    test_store();
    test_arbitration();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifill_arb.md
IFILL_ARB -- requirements
Module: ifill_arb

Interface
REQ-001 SHALL have parameter PA, default 22, physical address width in bits.
REQ-002 SHALL have parameter RV, default 16, data word width in bits (nibbles per data word = RV/4).
REQ-003 SHALL have parameter LINE_LENGTH, default 4, icache line length in bytes (nibbles per fill = LINE_LENGTH*2).
REQ-004 SHALL have ports as follows:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- i_req  in  1  fetch unit is presenting a valid fetch address.
- i_pull  in  1  icache miss indication.
- i_tag  in  PA-log2(LINE_LENGTH)  line address of the miss.
- fill_busy  out  1  fetch address must be held stable.
- wstrobe_d  out  1  icache nibble write strobe.
- dread  out  4  icache nibble data.
- d_req  in  1  data access request, held until d_ack.
- d_write  in  1  1 = store, 0 = load.
- d_addr  in  PA  data byte address; bit 0 ignored.
- d_wdata  in  RV  store data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  RV  load data.
- mem_req  out  1  memory transaction request.
- mem_gnt  in  1  memory accepts the request, one-cycle pulse.
- mem_write  out  1  transaction direction.
- mem_addr  out  PA  transaction start byte address.
- mem_len  out  1  0 = data word, 1 = line fill.
- mem_strobe  in  1  one nibble transferred this cycle.
- mem_rnib  in  4  read nibble, valid with mem_strobe.
- mem_wnib  out  4  write nibble, consumed on mem_strobe.

Function
REQ-005 SHALL implement states IDLE, IREQ, IXFER, REPLAY, DREQ, DXFER and DONE.
REQ-006 A fill request SHALL be i_req && i_pull; a data request SHALL be d_req.
REQ-007 IDLE arbitration:
- If only one request is present, it SHALL win.
- If both are present, the requester not served last SHALL win, tracked by the last_i flag.
- last_i SHALL reset to 0, so data wins the first tie.
REQ-008 On winning, the state SHALL go to IREQ or DREQ, and mem_req SHALL rise the next cycle.
REQ-009 mem_addr, mem_write and mem_len SHALL be stable while mem_req is high.
- Fill: mem_addr = {i_tag, zeros}, mem_write = 0, mem_len = 1.
- Data: mem_addr = {d_addr[PA-1:1], 0}, mem_write = d_write, mem_len = 0.
REQ-010 On mem_gnt, mem_req SHALL drop in the same cycle's registered update, and the state SHALL go to IXFER or DXFER.
REQ-011 In IXFER, each mem_strobe SHALL store mem_rnib into a LINE_LENGTH*8-bit line buffer at nibble slot k, where k is a 0-based counter.
- Strobes may be non-contiguous.
- Strobes outside IXFER/DXFER SHALL be ignored.
REQ-012 After the LINE_LENGTH*2-th strobe, the state SHALL enter REPLAY.
- wstrobe_d SHALL be high for exactly LINE_LENGTH*2 consecutive cycles.
- dread SHALL present buffer slots 0,1,2,... in order (the icache performs nibble swapping).
- wstrobe_d SHALL never have gaps, since the icache resets its offset when the strobe is low.
REQ-013 fill_busy SHALL be high from the IREQ entry cycle through the last wstrobe_d cycle inclusive.
REQ-014 In DXFER, nibble k SHALL map to bits [(k^1)*4+3:(k^1)*4].
- Loads: mem_rnib is captured into d_rdata at that position.
- Stores: mem_wnib is driven from d_wdata at that position.
REQ-015 After RV/4 strobes, the state SHALL enter DONE, d_ack SHALL pulse for one cycle, and the state SHALL return to IDLE.
- d_rdata SHALL be valid during the d_ack cycle and held until the next load completes.
REQ-016 After REPLAY, the state SHALL return to IDLE; REPLAY is treated as the fill's completion cycle.
- last_i SHALL update on completion: 1 for fill, 0 for data.
REQ-017 Requests arriving outside IDLE SHALL wait, and SHALL NOT be dropped.
REQ-018 Deassertion of i_req or i_pull after the IREQ entry cycle SHALL NOT abort the fill.
REQ-019 The nibble counter SHALL be log2(LINE_LENGTH*2) bits wide, SHALL clear on each transfer start, and SHALL NOT wrap within a transfer.

Reset
REQ-020 When reset = 0, asynchronously:
- The state SHALL be IDLE.
- mem_req, wstrobe_d, fill_busy and d_ack SHALL be 0.
- dread, mem_wnib and d_rdata SHALL be 0.
- last_i SHALL be 0 and the counter SHALL be 0.
REQ-021 Reset mid-transfer SHALL abandon the transfer without completing it; no wstrobe_d and no d_ack SHALL be issued for it.

Verification
REQ-022 Fill: i_req = i_pull = 1, i_tag = 0x12345, memory returns nibbles 1..8 with gaps.
- Required: mem_addr = 0x48D14, mem_len = 1.
- wstrobe_d high for 8 consecutive cycles with dread = 1,2,...,8.
- fill_busy drops after the last strobe.
REQ-023 Load: d_addr = 0x001235, nibbles A,B,C,D.
- Required: mem_addr = 0x001234, d_ack pulses once, d_rdata = 0xCDAB.
REQ-024 Store: d_wdata = 0x5678.
- Required: mem_wnib sequence = 7,8,5,6, then d_ack; no wstrobe_d.
REQ-025 Simultaneous fill and data request after reset.
- Required: data is served first, then the fill.
- A repeated tie then serves data (last_i = 1); a third tie serves the fill.
REQ-026 Reset asserted after 3 fill nibbles.
- Required: all outputs 0 immediately, with no wstrobe_d.
- A new fill after release starts at slot 0.
